// File: rtl/ysyx_23060203_mul_pkg.sv
// Shared types and Booth recoding helper for the radix-4 multiplier.
// Digits are kept as 3-bit signed selects in the range -2..+2.
package ysyx_23060203_mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef logic signed [2:0] digit_t;

   function automatic digit_t booth_digit(input logic [2:0] t);
      digit_t d;
      case (t)
         3'b001, 3'b010: d = 3'sb001;
         3'b011:         d = 3'sb010;
         3'b100:         d = 3'sb110;
         3'b101, 3'b110: d = 3'sb111;
         default:        d = 3'sb000;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ysyx_23060203_booth_r4_pp.sv
// Radix-4 Booth partial product: d * a for one recoded digit.
// Two guard bits keep +/-2a exact for any E-bit signed a.
module ysyx_23060203_booth_r4_pp
   import ysyx_23060203_mul_pkg::*;
#(
   parameter int E = 34
) (
   input  logic [2:0]   i_triple,
   input  logic [E-1:0] i_a,
   output logic [E+1:0] o_pp
);

   digit_t       w_d;
   logic [E+1:0] w_pos;
   logic [E+1:0] w_neg;

   assign w_d   = booth_digit(i_triple);
   assign w_pos = {{2{i_a[E-1]}}, i_a};
   assign w_neg = ~w_pos + (E+2)'(1);

   always_comb begin
      o_pp = '0;
      case (w_d)
         3'b001:  o_pp = w_pos;
         3'b010:  o_pp = w_pos << 1;
         3'b111:  o_pp = w_neg;
         3'b110:  o_pp = w_neg << 1;
         default: o_pp = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_23060203_mul_booth_r4.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle,
// valid/ready on both sides, optional early exit, flushable.
module ysyx_23060203_mul_booth_r4
   import ysyx_23060203_mul_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 4,
   parameter int EARLY_OUT = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic [1:0]         in_sign,
   input  logic               in_hi,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [WIDTH-1:0]   out_res,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int E  = WIDTH + 2;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW+1:0] SH_N = (CW+2)'(2 * N);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [E-1:0]     r_a;
   logic [E:0]       r_bx;
   logic [2*E-1:0]   r_p;
   logic             r_hi;
   logic [TAG_W-1:0] r_tag;

   logic             w_acc;
   logic             w_early;
   logic             w_last;
   logic [E-1:0]     w_a_ext;
   logic [E-1:0]     w_b_ext;
   logic [E+1:0]     w_pp;
   logic [E+1:0]     w_hi_sum;
   logic [CW+1:0]    w_shamt;
   logic [2*E-1:0]   w_sh;

   assign w_a_ext = {{2{in_sign[1] & in_a[WIDTH-1]}}, in_a};
   assign w_b_ext = {{2{in_sign[0] & in_b[WIDTH-1]}}, in_b};

   assign in_ready = (r_state == S_IDLE) | flush |
                     ((r_state == S_DONE) & out_ready);
   assign w_acc    = in_valid & in_ready;

   // r_bx holds {b_ext, b[-1]} shifted so the live triple sits at [2:0]
   assign w_early = (EARLY_OUT != 0) && ((&r_bx) || !(|r_bx));
   assign w_last  = (r_cnt == LAST);

   ysyx_23060203_booth_r4_pp #(
      .E(E)
   ) u_pp (
      .i_triple (r_bx[2:0]),
      .i_a      (r_a),
      .o_pp     (w_pp)
   );

   // adding at bit E only touches the upper half of P
   assign w_hi_sum = {{2{r_p[2*E-1]}}, r_p[2*E-1:E]} + w_pp;
   assign w_shamt  = SH_N - {1'b0, r_cnt, 1'b0};
   assign w_sh     = $signed(r_p) >>> w_shamt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else if (w_acc) begin
         r_state <= S_BUSY;
      end else begin
         case (r_state)
            S_BUSY: begin
               if (flush)
                  r_state <= S_IDLE;
               else if (w_early || w_last)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               if (flush || out_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_acc) begin
         r_a   <= w_a_ext;
         r_bx  <= {w_b_ext, 1'b0};
         r_p   <= '0;
         r_cnt <= '0;
         r_hi  <= in_hi;
         r_tag <= in_tag;
      end else if (r_state == S_BUSY) begin
         if (w_early) begin
            r_p <= w_sh;
         end else begin
            r_p   <= {w_hi_sum, r_p[E-1:2]};
            r_bx  <= {{2{r_bx[E]}}, r_bx[E:2]};
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out_valid = (r_state == S_DONE) & ~flush;
   assign out_prod  = r_p[2*WIDTH-1:0];
   assign out_res   = r_hi ? r_p[2*WIDTH-1:WIDTH] : r_p[WIDTH-1:0];
   assign out_tag   = r_tag;

endmodule

// File: tb/tb_ysyx_23060203_mul_booth_r4.sv
// Scoreboard bench: instance 0 fixed latency, instance 1 early-out.
// Drivers push expected results; per-instance monitors pop and compare.
module tb_ysyx_23060203_mul_booth_r4;

   typedef struct {
      logic [63:0] p;
      logic [31:0] r;
      logic [3:0]  t;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fl   [2];
   logic        iv   [2];
   logic        orr  [2];
   logic        hi   [2];
   logic [1:0]  sg   [2];
   logic [3:0]  tg   [2];
   logic [31:0] a    [2];
   logic [31:0] b    [2];
   logic        ir   [2];
   logic        ov   [2];
   logic [63:0] prod [2];
   logic [31:0] res  [2];
   logic [3:0]  otag [2];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_23060203_mul_booth_r4 #(
      .WIDTH(32), .TAG_W(4), .EARLY_OUT(0)
   ) u0 (
      .clock(clk), .reset(rst_n), .flush(fl[0]),
      .in_ready(ir[0]), .in_valid(iv[0]), .in_sign(sg[0]),
      .in_hi(hi[0]), .in_tag(tg[0]), .in_a(a[0]), .in_b(b[0]),
      .out_ready(orr[0]), .out_valid(ov[0]), .out_prod(prod[0]),
      .out_res(res[0]), .out_tag(otag[0])
   );

   ysyx_23060203_mul_booth_r4 #(
      .WIDTH(32), .TAG_W(4), .EARLY_OUT(1)
   ) u1 (
      .clock(clk), .reset(rst_n), .flush(fl[1]),
      .in_ready(ir[1]), .in_valid(iv[1]), .in_sign(sg[1]),
      .in_hi(hi[1]), .in_tag(tg[1]), .in_a(a[1]), .in_b(b[1]),
      .out_ready(orr[1]), .out_valid(ov[1]), .out_prod(prod[1]),
      .out_res(res[1]), .out_tag(otag[1])
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", nm, act, req);
      end
   endtask

   task automatic push_exp(input int g, input logic h, input logic [3:0] t,
                           input logic [63:0] p, input int lat);
      exp_t e;
      e.p   = p;
      e.r   = h ? p[63:32] : p[31:0];
      e.t   = t;
      e.lat = lat;
      e.acc = cyc;
      if (g == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // starts and returns at posedge+1; n = cycles waited for in_ready
   task automatic issue(input int g, input logic [1:0] s, input logic h,
                        input logic [3:0] t, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] p,
                        input int lat, input bit push, output int n);
      sg[g] = s; hi[g] = h; tg[g] = t; a[g] = x; b[g] = y;
      iv[g] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ir[g] && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL accept_timeout%0d act=not_ready req=ready", g);
      end
      @(posedge clk);
      #1;
      iv[g] = 1'b0;
      if (push) push_exp(g, h, t, p, lat);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      exp_t e;
      bit   seen = 1'b0;
      bit   got;
      always @(negedge clk) begin
         if (rst_n) begin
            if (fl[g])
               chk($sformatf("valid_in_flush%0d", g), 64'(ov[g]), 64'd0);
            if (ov[g]) begin
               got = 1'b0;
               if (g == 0 && q0.size() > 0) begin e = q0[0]; got = 1'b1; end
               if (g == 1 && q1.size() > 0) begin e = q1[0]; got = 1'b1; end
               if (!got) begin
                  total++; bad++;
                  $display("FAIL unexpected_valid%0d act=%h req=none",
                           g, prod[g]);
               end else begin
                  chk($sformatf("prod%0d", g), prod[g], e.p);
                  chk($sformatf("res%0d", g), 64'(res[g]), 64'(e.r));
                  chk($sformatf("tag%0d", g), 64'(otag[g]), 64'(e.t));
                  if (!seen && e.lat >= 0)
                     chk($sformatf("latency%0d", g),
                         64'(cyc - e.acc + 1), 64'(e.lat));
                  seen = 1'b1;
                  if (orr[g]) begin
                     seen = 1'b0;
                     if (g == 0) void'(q0.pop_front());
                     else        void'(q1.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         fl[g] = 0; iv[g] = 0; orr[g] = 1; hi[g] = 0;
         sg[g] = 0; tg[g] = 0; a[g] = 0; b[g] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst_valid%0d", g), 64'(ov[g]), 64'd0);
         chk($sformatf("rst_ready%0d", g), 64'(ir[g]), 64'd1);
      end
      rst_n = 1'b1;

      // fixed latency, all sign modes
      issue(0, 2'b00, 0, 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF,
            64'hFFFFFFFE00000001, 18, 1, n);
      issue(0, 2'b11, 1, 4'h2, 32'h80000000, 32'h80000000,
            64'h4000000000000000, 18, 1, n);
      issue(0, 2'b10, 1, 4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF,
            64'hFFFFFFFF00000001, 18, 1, n);
      issue(0, 2'b01, 0, 4'h9, 32'h00000003, 32'hFFFFFFFE,
            64'hFFFFFFFFFFFFFFFA, 18, 1, n);

      // early-out instance
      issue(1, 2'b11, 0, 4'h5, 32'd7, 32'd3, 64'd21, 4, 1, n);
      issue(1, 2'b11, 0, 4'h6, 32'h12345678, 32'd0, 64'd0, 2, 1, n);
      issue(1, 2'b11, 0, 4'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 64'd3, 3, 1, n);
      issue(1, 2'b00, 1, 4'h8, 32'd5, 32'h80000000,
            64'h0000000280000000, 18, 1, n);

      // flush with a new op offered in the same cycle
      issue(1, 2'b11, 0, 4'hA, 32'd5, 32'h7FFFFFFF, 64'd0, -1, 0, n);
      repeat (4) @(posedge clk);
      #1;
      fl[1] = 1; iv[1] = 1; sg[1] = 2'b11; hi[1] = 0; tg[1] = 4'hB;
      a[1] = 32'd2; b[1] = 32'd3;
      @(posedge clk);
      #1;
      fl[1] = 0; iv[1] = 0;
      push_exp(1, 1'b0, 4'hB, 64'd6, 4);

      // flush with nothing offered
      issue(1, 2'b11, 0, 4'h1, 32'd5, 32'h7FFFFFFF, 64'd0, -1, 0, n);
      repeat (3) @(posedge clk);
      #1;
      fl[1] = 1;
      @(posedge clk);
      #1;
      fl[1] = 0;
      chk("flush_idle_ready", 64'(ir[1]), 64'd1);
      chk("flush_idle_valid", 64'(ov[1]), 64'd0);

      // backpressure hold, then back-to-back accept
      orr[1] = 0;
      issue(1, 2'b11, 0, 4'hC, 32'd6, 32'd7, 64'd42, 4, 1, n);
      n = 0;
      while (!ov[1] && n < 50) begin
         n++;
         @(negedge clk);
      end
      repeat (10) @(posedge clk);
      #1;
      orr[1] = 1;
      issue(1, 2'b01, 1, 4'hD, 32'hFFFFFFFF, 32'd2,
            64'h00000001FFFFFFFE, 4, 1, n);
      chk("b2b_wait", 64'(n), 64'd0);

      // reset in the middle of an operation
      issue(1, 2'b11, 0, 4'h3, 32'd9, 32'h7FFFFFFF, 64'd0, -1, 0, n);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      chk("midrst_valid", 64'(ov[1]), 64'd0);
      chk("midrst_ready", 64'(ir[1]), 64'd1);
      issue(1, 2'b11, 0, 4'hE, 32'hFFFFFFFE, 32'd5,
            64'hFFFFFFFFFFFFFFF6, 4, 1, n);

      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 300) begin
         n++;
         @(posedge clk);
      end
      #1;
      chk("drain", 64'(q0.size() + q1.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
